// File: rtl/bcd_display_counter_pkg.sv
// Shared types and seven-segment constants for the BCD display counter.
// Segment bytes are active-low {dp,g,f,e,d,c,b,a}, with the decimal point held off.
package bcd_display_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] SEG_0     = 8'b1100_0000;
  localparam logic [7:0] SEG_1     = 8'b1111_1001;
  localparam logic [7:0] SEG_2     = 8'b1010_0100;
  localparam logic [7:0] SEG_3     = 8'b1011_0000;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b1001_0010;
  localparam logic [7:0] SEG_6     = 8'b1000_0010;
  localparam logic [7:0] SEG_7     = 8'b1111_1000;
  localparam logic [7:0] SEG_8     = 8'b1000_0000;
  localparam logic [7:0] SEG_9     = 8'b1001_0000;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic bcd_digit_t bcd_saturate(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

  function automatic logic [7:0] seg_code(input bcd_digit_t d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_display_counter_if.sv
// Signal bundle for the BCD display counter: control inputs and display outputs.
// load is a single-cycle strobe with no ready: it is taken on the rising edge at which it is seen high.
interface bcd_display_counter_if #(
  parameter int DIGITS = 6
);
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  tc;
  logic [8*DIGITS-1:0]   hex;

  modport master (
    output en, up_dn, load, load_val,
    input  count_bcd, tc, hex
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count_bcd, tc, hex
  );
endinterface

// File: rtl/bcd_display_counter_seg7_decode.sv
// One BCD digit to active-low seven-segment byte, with a forced-blank override.
module seg7_decode
  import bcd_display_counter_pkg::*;
(
  input  bcd_digit_t  digit,
  input  logic        blank,
  output logic [7:0]  seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_code(digit);
  end

endmodule

// File: rtl/bcd_display_counter.sv
// Prescaled up/down BCD counter with load, wrap pulse and registered 7-segment outputs.
// Optional BLANK_LEADING_ZEROS_EN blanks digits above the most significant non-zero one.
module bcd_display_counter
  import bcd_display_counter_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 10000000
) (
  input  logic                ADC_CLK_10,
  input  logic                RST,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                tc,
  output logic [8*DIGITS-1:0] HEX
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  function automatic logic [8*DIGITS-1:0] hex_reset_val();
    logic [8*DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef BLANK_LEADING_ZEROS_EN
      v[8*i +: 8] = (i == 0) ? SEG_0 : SEG_BLANK;
`else
      v[8*i +: 8] = SEG_0;
`endif
    end
    return v;
  endfunction

  localparam logic [8*DIGITS-1:0] HEX_RESET = hex_reset_val();

  logic [PW-1:0]         presc_q, presc_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic                  tc_q, tc_d;
  logic [8*DIGITS-1:0]   hex_q, hex_d;
  logic [4*DIGITS-1:0]   stepped;
  logic                  wrap;
  logic                  tick;
  logic [DIGITS-1:0]     blank;

  assign tick = en && (presc_q == PRESC_MAX);

  // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
  always_comb begin : step_logic
    logic       carry;
    bcd_digit_t dig;
    stepped = count_q;
    carry   = 1'b1;
    dig     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (dig == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap = carry;
  end

  always_comb begin : next_state
    presc_d = presc_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      presc_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
        count_d[4*i +: 4] = bcd_saturate(load_val[4*i +: 4]);
      end
    end else if (en) begin
      if (tick) begin
        presc_d = '0;
        count_d = stepped;
        tc_d    = wrap;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin : blank_logic
`ifdef BLANK_LEADING_ZEROS_EN
    logic seen_nz;
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen_nz  = seen_nz | (count_q[4*i +: 4] != 4'd0);
      blank[i] = ~seen_nz;
    end
`else
    blank = '0;
`endif
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit (count_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (hex_d[8*g +: 8])
    );
  end

  always_ff @(posedge ADC_CLK_10 or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      hex_q   <= HEX_RESET;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      hex_q   <= hex_d;
    end
  end

  assign count_bcd = count_q;
  assign tc        = tc_q;
  assign HEX       = hex_q;

endmodule
